// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-to-one memory request arbiter.
// Owner tag encoding used by the grant logic and the in-order tag FIFO,
// plus the fixed access size used for instruction fetches.
// Ports: none (package).
package mem_arb_pkg;

    localparam logic       OWNER_INST = 1'b0;
    localparam logic       OWNER_DATA = 1'b1;

    // Instruction fetches are always full 32-bit words.
    localparam logic [2:0] INST_SIZE  = 3'd2;

endpackage

// File: rtl/arb_tag_fifo.sv
// Purpose: in-order 1-bit owner-tag FIFO, one entry per outstanding request.
// Latency: a pushed tag is visible on head the cycle after the push.
// Backpressure: exposes full/empty; the caller must not push when full or pop when empty.
// Ports: clk/resetn (sync, active-low); push/din write a tag; pop drops the head;
//        head/empty/full report state from the registered count.
import mem_arb_pkg::*;

module arb_tag_fifo #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic head,
    output logic empty,
    output logic full
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic [MAX_OUTSTANDING-1:0] mem;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;

    // Pointers are exactly log2(depth) wide, so they wrap without compare logic.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(MAX_OUTSTANDING));

endmodule

// File: rtl/mem_req_arbiter.sv
// Purpose: shares one request/response memory port between inst and data channels.
// Latency: zero-cycle combinational grant, payload mux and response routing.
// Backpressure: mem_req withheld while MAX_OUTSTANDING requests await data_ok.
// Ports: inst_* / data_* core channels, mem_* downstream port, spurious_ok sticky
//        flag for responses with nothing outstanding. clk, resetn (sync, active-low).
// Build option: define MEM_ARB_RR_EN for round-robin tie-break; otherwise DATA
//        always wins a tie.
import mem_arb_pkg::*;

module mem_req_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_cache,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_cache,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_cache,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        spurious_ok
);

    logic owner;
    logic lock;
    logic lock_owner;
    logic can_issue;
    logic accept;
    logic fifo_pop;
    logic fifo_head;
    logic fifo_empty;
    logic fifo_full;
    logic tie_winner;

`ifdef MEM_ARB_RR_EN
    logic rr_last;

    // Tie goes to whichever channel was not the most recent accept.
    assign tie_winner = ~rr_last;

    always_ff @(posedge clk) begin
        if (!resetn)     rr_last <= OWNER_INST;
        else if (accept) rr_last <= owner;
    end
`else
    assign tie_winner = OWNER_DATA;
`endif

    // A pending (offered but unaccepted) request pins the owner so the
    // downstream payload stays stable until its address phase completes.
    always_comb begin
        owner = OWNER_INST;
        if (lock)                      owner = lock_owner;
        else if (inst_req && data_req) owner = tie_winner;
        else if (data_req)             owner = OWNER_DATA;
        else                           owner = OWNER_INST;
    end

    // Issue is decided from the registered count only; a same-cycle pop
    // does not open a slot until the next cycle.
    assign can_issue = !fifo_full;
    assign mem_req   = (inst_req || data_req) && can_issue;
    assign accept    = mem_req && mem_addr_ok;

    always_comb begin
        if (owner == OWNER_DATA) begin
            mem_cache = data_cache;
            mem_wr    = data_wr;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_size  = data_size;
            mem_wdata = data_wdata;
        end else begin
            mem_cache = inst_cache;
            mem_wr    = 1'b0;
            mem_wstrb = 4'b0000;
            mem_addr  = inst_addr;
            mem_size  = INST_SIZE;
            mem_wdata = 32'd0;
        end
    end

    assign inst_addr_ok = accept && (owner == OWNER_INST);
    assign data_addr_ok = accept && (owner == OWNER_DATA);

    // Lock is held (not cleared) while full, since mem_req is low then.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock        <= 1'b0;
            lock_owner  <= OWNER_INST;
            spurious_ok <= 1'b0;
        end else begin
            if (mem_req && !mem_addr_ok) begin
                lock       <= 1'b1;
                lock_owner <= owner;
            end else if (accept) begin
                lock       <= 1'b0;
            end
            if (mem_data_ok && fifo_empty) spurious_ok <= 1'b1;
        end
    end

    assign fifo_pop = mem_data_ok && !fifo_empty;

    arb_tag_fifo #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .din    (owner),
        .pop    (fifo_pop),
        .head   (fifo_head),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign inst_data_ok = fifo_pop && (fifo_head == OWNER_INST);
    assign data_data_ok = fifo_pop && (fifo_head == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: expected owners are queued on each
// accept and popped when a response is presented, so routing is compared in order.
// Tie-break expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_cache;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_cache, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic [2:0]  data_size;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_cache, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_size;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        spurious_ok;

    int checks   = 0;
    int failures = 0;
    logic sb[$];

    localparam logic INST = 1'b0;
    localparam logic DATA = 1'b1;

`ifdef MEM_ARB_RR_EN
    localparam logic TIE2 = INST;
`else
    localparam logic TIE2 = DATA;
`endif

    always #5 clk = ~clk;

    mem_req_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_cache(data_cache), .data_wr(data_wr),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_size(data_size),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_cache(mem_cache), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .spurious_ok(spurious_ok)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_payload();
        inst_cache = 1'($urandom_range(0, 1));
        inst_addr  = $urandom;
        data_cache = 1'($urandom_range(0, 1));
        data_wr    = 1'($urandom_range(0, 1));
        data_wstrb = 4'($urandom_range(1, 15));
        data_addr  = $urandom;
        data_size  = 3'($urandom_range(0, 7));
        data_wdata = $urandom;
    endtask

    // One address-phase cycle: drive requests, check grant and payload.
    task automatic cycle_req(input string tag, input logic ir, input logic dr,
                             input logic aok, input logic exp_mreq, input logic exp_own);
        randomize_payload();
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = aok;
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk({tag, "_mem_req"}, mem_req, exp_mreq);
        if (exp_mreq) begin
            chk({tag, "_iaok"}, inst_addr_ok, aok && (exp_own == INST));
            chk({tag, "_daok"}, data_addr_ok, aok && (exp_own == DATA));
            if (exp_own == DATA) begin
                chk({tag, "_addr"}, mem_addr, data_addr);
                chk({tag, "_pay"}, {mem_cache, mem_wr, mem_wstrb, mem_size, mem_wdata[7:0]},
                    {data_cache, data_wr, data_wstrb, data_size, data_wdata[7:0]});
            end else begin
                chk({tag, "_addr"}, mem_addr, inst_addr);
                chk({tag, "_pay"}, {mem_cache, mem_wr, mem_wstrb, mem_size, mem_wdata[7:0]},
                    {inst_cache, 1'b0, 4'b0000, 3'd2, 8'd0});
                chk({tag, "_wdata"}, mem_wdata, 32'd0);
            end
            if (aok) sb.push_back(exp_own);
        end else begin
            chk({tag, "_iaok"}, inst_addr_ok, 1'b0);
            chk({tag, "_daok"}, data_addr_ok, 1'b0);
        end
        step();
    endtask

    // One response cycle; with nothing queued, no channel may see data_ok.
    task automatic respond(input string tag, input logic [31:0] rd,
                           input logic ir, input logic dr, input logic exp_mreq);
        logic exp;
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        @(negedge clk);
        chk({tag, "_mem_req"}, mem_req, exp_mreq);
        chk({tag, "_irdata"}, inst_rdata, rd);
        chk({tag, "_drdata"}, data_rdata, rd);
        if (sb.size() == 0) begin
            chk({tag, "_idok"}, inst_data_ok, 1'b0);
            chk({tag, "_ddok"}, data_data_ok, 1'b0);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_idok"}, inst_data_ok, exp == INST);
            chk({tag, "_ddok"}, data_data_ok, exp == DATA);
        end
        step();
        mem_data_ok = 1'b0;
        inst_req    = 1'b0;
        data_req    = 1'b0;
    endtask

    task automatic idle_cycle(input string tag);
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk({tag, "_mem_req"}, mem_req, 1'b0);
        chk({tag, "_dok"}, {inst_data_ok, data_data_ok}, 2'b00);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        inst_req = 1'b0; inst_cache = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_cache = 1'b0; data_wr = 1'b0;
        data_wstrb = '0; data_addr = '0; data_size = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_outputs", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok,
                            data_data_ok, spurious_ok, mem_wr, mem_wstrb}, '0);
        chk("rst_addr", mem_addr, 32'd0);
        step();
        resetn = 1'b1;

        // Single fetch with a known address and response word.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_cache = 1'b1;
        data_req = 1'b0; data_wr = 1'b1; data_size = 3'd7; data_wstrb = 4'hF;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("fetch_mem_addr", mem_addr, 32'hBFC0_0000);
        chk("fetch_size_wr", {mem_size, mem_wr, mem_wstrb}, {3'd2, 1'b0, 4'b0000});
        chk("fetch_iaok", inst_addr_ok, 1'b1);
        sb.push_back(INST);
        step();
        idle_cycle("fetch_gap");
        respond("fetch_resp", 32'h3C1A_BFC0, 1'b0, 1'b0, 1'b0);

        // Tie on two consecutive accept cycles.
        cycle_req("tie1", 1'b1, 1'b1, 1'b1, 1'b1, DATA);
        cycle_req("tie2", 1'b1, 1'b1, 1'b1, 1'b1, TIE2);
        respond("tie_r1", $urandom, 1'b0, 1'b0, 1'b0);
        respond("tie_r2", $urandom, 1'b0, 1'b0, 1'b0);

        // DATA offered but stalled for 3 cycles, then accepted, then INST.
        for (int i = 0; i < 3; i++)
            cycle_req("dlock_wait", 1'b1, 1'b1, 1'b0, 1'b1, DATA);
        cycle_req("dlock_acc", 1'b1, 1'b1, 1'b1, 1'b1, DATA);
        cycle_req("dlock_inst", 1'b1, 1'b0, 1'b1, 1'b1, INST);
        respond("dlock_r1", $urandom, 1'b0, 1'b0, 1'b0);
        respond("dlock_r2", $urandom, 1'b0, 1'b0, 1'b0);

        // INST stalled: a DATA request arriving later must not steal the port.
        cycle_req("ilock_wait", 1'b1, 1'b0, 1'b0, 1'b1, INST);
        cycle_req("ilock_tie", 1'b1, 1'b1, 1'b0, 1'b1, INST);
        cycle_req("ilock_acc", 1'b1, 1'b1, 1'b1, 1'b1, INST);
        cycle_req("ilock_data", 1'b0, 1'b1, 1'b1, 1'b1, DATA);
        respond("ilock_r1", $urandom, 1'b0, 1'b0, 1'b0);
        respond("ilock_r2", $urandom, 1'b0, 1'b0, 1'b0);

        // Fill the tag FIFO back-to-back, then hit the full limit.
        cycle_req("fill0", 1'b1, 1'b0, 1'b1, 1'b1, INST);
        cycle_req("fill1", 1'b0, 1'b1, 1'b1, 1'b1, DATA);
        cycle_req("fill2", 1'b1, 1'b0, 1'b1, 1'b1, INST);
        cycle_req("fill3", 1'b0, 1'b1, 1'b1, 1'b1, DATA);
        cycle_req("full_block", 1'b1, 1'b0, 1'b1, 1'b0, INST);
        respond("full_pop", $urandom, 1'b1, 1'b0, 1'b0);
        cycle_req("full_reissue", 1'b1, 1'b0, 1'b1, 1'b1, INST);
        for (int i = 0; i < 4; i++)
            respond("order_r", $urandom, 1'b0, 1'b0, 1'b0);

        // Response with nothing outstanding.
        @(negedge clk);
        chk("spur_before", spurious_ok, 1'b0);
        step();
        respond("spur_resp", 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("spur_set", spurious_ok, 1'b1);
        step();
        idle_cycle("spur_idle");
        @(negedge clk);
        chk("spur_sticky", spurious_ok, 1'b1);

        // Synchronous reset clears the sticky flag.
        step();
        resetn = 1'b0;
        step();
        @(negedge clk);
        chk("spur_rst", spurious_ok, 1'b0);
        step();
        resetn = 1'b1;
        cycle_req("post_rst", 1'b1, 1'b1, 1'b1, 1'b1, DATA);
        respond("post_rst_r", $urandom, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
